kd_sort_ctrl: RTL and testbench

Sequencer that sorts a heap-indexed kd-tree of cluster centers stored in an external node RAM by repeatedly driving the cluster compare-exchange element (CE) over every internal node. It reads each parent and its two children, presents them to the CE with the node's split axis, and writes back only the entries the CE reports as switched. Passes repeat until one full pass makes no write, or a pass limit is reached. It sits between the top-level kd-tree control (start/done) and the single shared CE instance.

---
 rtl/kd_pkg.sv | 22 ++
 rtl/kd_sort_ctrl_if.sv | 23 ++
 rtl/kd_sort_ctrl.sv | 96 +++++++++
 tb/tb_kd_sort_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// kd_pkg: sizes, FSM states and heap-index helpers shared by the kd-tree sort controller.
package kd_pkg;
  localparam int dim = 3;
  localparam int data_range = 255;
  localparam int dim_size = $clog2(data_range);
  localparam int center_size = dim * dim_size;
  localparam int axis_size = $clog2(dim);
  typedef logic [center_size-1:0] center_t;
  typedef logic [axis_size-1:0] axis_t;
  typedef enum logic [3:0] {IDLE, RD_P, RD_L, RD_R, CAPT, EVAL, WR_L, WR_P, WR_R, NEXT, DONE} state_t;
  function automatic int left_child(int i);
    return 2 * i + 1;
  endfunction
  function automatic int right_child(int i);
    return 2 * i + 2;
  endfunction
  function automatic int depth_of(int i);
    int d = 0;
    for (int b = 1; b < 31; b++) if ((i + 1) >> b != 0) d = b;
    return d;
  endfunction
endpackage

// File: rtl/kd_sort_ctrl_if.sv
// kd_sort_ctrl_if: node RAM port plus compare-exchange element bundle of the kd-tree sorter.
interface kd_sort_ctrl_if #(parameter int levels = 3);
  import kd_pkg::*;
  localparam int addr_size = $clog2(2 ** levels - 1);
  logic mem_re, mem_we, ce_en, ce_sorting;
  logic ce_left_switch, ce_parent_switch, ce_right_switch;
  logic [addr_size-1:0] mem_raddr, mem_waddr;
  center_t mem_rdata, mem_wdata;
  center_t ce_left, ce_parent, ce_right, ce_new_left, ce_new_parent, ce_new_right;
  axis_t ce_axis;
  modport master(
    output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
    output ce_en, ce_sorting, ce_left, ce_parent, ce_right, ce_axis,
    input mem_rdata, ce_new_left, ce_new_parent, ce_new_right,
    input ce_left_switch, ce_parent_switch, ce_right_switch
  );
  modport slave(
    input mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
    input ce_en, ce_sorting, ce_left, ce_parent, ce_right, ce_axis,
    output mem_rdata, ce_new_left, ce_new_parent, ce_new_right,
    output ce_left_switch, ce_parent_switch, ce_right_switch
  );
endinterface

// File: rtl/kd_sort_ctrl.sv
// kd_sort_ctrl: sweeps every internal node of a heap-indexed kd-tree through the shared CE,
// writing back only switched entries, until a pass is clean or the pass limit is reached.
module kd_sort_ctrl
  import kd_pkg::*;
#(
  parameter int levels = 3,
  parameter int max_passes = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic [$clog2(max_passes+1)-1:0] pass_cnt,
  kd_sort_ctrl_if.master bus
);
  localparam int internal = 2 ** (levels - 1) - 1;
  localparam int addr_size = $clog2(2 ** levels - 1);
  localparam int pass_size = $clog2(max_passes + 1);
  typedef logic [addr_size-1:0] addr_t;
  state_t state_q, state_d;
  addr_t i_q, i_d, lchild, rchild;
  axis_t axis_q, axis_d;
  logic [pass_size-1:0] pass_q, pass_d, pass_inc;
  logic dirty_q, dirty_d, timeout_q, timeout_d, last_node, step_depth;
  center_t par_q, par_d, lft_q, lft_d, rgt_q, rgt_d;
  center_t new_l_q, new_l_d, new_p_q, new_p_d, new_r_q, new_r_d;
  logic [2:0] sw_q, sw_d;  // {left, parent, right}
  assign lchild = addr_t'(left_child(int'(i_q)));
  assign rchild = addr_t'(right_child(int'(i_q)));
  assign last_node = i_q == addr_t'(internal - 1);
  assign step_depth = ((int'(i_q) + 2) & (int'(i_q) + 1)) == 0;
  assign pass_inc = pass_q + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE; i_q <= '0; axis_q <= '0; pass_q <= '0; dirty_q <= 1'b0; timeout_q <= 1'b0;
      par_q <= '0; lft_q <= '0; rgt_q <= '0; new_l_q <= '0; new_p_q <= '0; new_r_q <= '0; sw_q <= '0;
    end else begin
      state_q <= state_d; i_q <= i_d; axis_q <= axis_d; pass_q <= pass_d; dirty_q <= dirty_d;
      timeout_q <= timeout_d; par_q <= par_d; lft_q <= lft_d; rgt_q <= rgt_d;
      new_l_q <= new_l_d; new_p_q <= new_p_d; new_r_q <= new_r_d; sw_q <= sw_d;
    end
  end
  always_comb begin
    state_d = state_q; i_d = i_q; axis_d = axis_q; pass_d = pass_q; dirty_d = dirty_q;
    timeout_d = timeout_q; par_d = par_q; lft_d = lft_q; rgt_d = rgt_q;
    new_l_d = new_l_q; new_p_d = new_p_q; new_r_d = new_r_q; sw_d = sw_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RD_P; i_d = '0; axis_d = '0; pass_d = '0; dirty_d = 1'b0; timeout_d = 1'b0;
      end
      RD_P: state_d = RD_L;
      RD_L: begin par_d = bus.mem_rdata; state_d = RD_R; end
      RD_R: begin lft_d = bus.mem_rdata; state_d = CAPT; end
      CAPT: begin rgt_d = bus.mem_rdata; state_d = EVAL; end
      EVAL: begin
        new_l_d = bus.ce_new_left; new_p_d = bus.ce_new_parent; new_r_d = bus.ce_new_right;
        sw_d = {bus.ce_left_switch, bus.ce_parent_switch, bus.ce_right_switch};
        state_d = bus.ce_left_switch ? WR_L : bus.ce_parent_switch ? WR_P : bus.ce_right_switch ? WR_R : NEXT;
      end
      WR_L: begin dirty_d = 1'b1; state_d = sw_q[1] ? WR_P : sw_q[0] ? WR_R : NEXT; end
      WR_P: begin dirty_d = 1'b1; state_d = sw_q[0] ? WR_R : NEXT; end
      WR_R: begin dirty_d = 1'b1; state_d = NEXT; end
      NEXT: if (!last_node) begin
        i_d = i_q + 1'b1;
        axis_d = !step_depth ? axis_q : axis_q == axis_t'(dim - 1) ? '0 : axis_q + 1'b1;
        state_d = RD_P;
      end else begin
        pass_d = pass_inc;
        if (dirty_q && int'(pass_inc) < max_passes) begin
          i_d = '0; axis_d = '0; dirty_d = 1'b0; state_d = RD_P;
        end else begin
          timeout_d = dirty_q; state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign timeout = timeout_q;
  assign pass_cnt = pass_q;
  assign bus.mem_re = state_q inside {RD_P, RD_L, RD_R};
  assign bus.mem_raddr = state_q == RD_P ? i_q : state_q == RD_L ? lchild : state_q == RD_R ? rchild : '0;
  assign bus.mem_we = state_q inside {WR_L, WR_P, WR_R};
  assign bus.mem_waddr = state_q == WR_L ? lchild : state_q == WR_P ? i_q : state_q == WR_R ? rchild : '0;
  assign bus.mem_wdata = state_q == WR_L ? new_l_q : state_q == WR_P ? new_p_q : state_q == WR_R ? new_r_q : '0;
  assign bus.ce_en = state_q == EVAL;
  assign bus.ce_sorting = state_q == EVAL;
  assign bus.ce_left = lft_q;
  assign bus.ce_parent = par_q;
  assign bus.ce_right = rgt_q;
  assign bus.ce_axis = axis_q;
endmodule

// File: tb/tb_kd_sort_ctrl.sv
// tb_kd_sort_ctrl: two controllers (levels 3 / 8 passes, levels 4 / 1 pass) against RAM and CE models.
`timescale 1ns/1ps
module tb_kd_sort_ctrl;
  import kd_pkg::*;
  typedef struct packed {logic [3:0] addr; center_t data;} wr_t;
  typedef struct packed {center_t l, p, r; logic [2:0] sw;} ce_t;
  logic clk = 0, rst = 0, start_a = 0, start_b = 0, load_a = 0, load_b = 0;
  logic busy_a, done_a, timeout_a, busy_b, done_b, timeout_b;
  logic [3:0] pass_a;
  logic [0:0] pass_b;
  center_t mem_a[7], img_a[7], mem_b[15], img_b[15];
  wr_t obs_wr_a[$], obs_wr_b[$], exp_wr[$];
  int obs_ax_a[$], obs_ax_b[$], exp_ax[$];
  int vectors = 0, miscompares = 0;
  ce_t ce_a, ce_b;
  kd_sort_ctrl_if #(.levels(3)) bus_a ();
  kd_sort_ctrl_if #(.levels(4)) bus_b ();
  kd_sort_ctrl #(.levels(3), .max_passes(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .timeout(timeout_a), .pass_cnt(pass_a), .bus(bus_a));
  kd_sort_ctrl #(.levels(4), .max_passes(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .pass_cnt(pass_b), .bus(bus_b));
  always #5 clk = ~clk;

  function automatic int key(center_t x, axis_t ax);
    return int'(x[int'(ax) * dim_size +: dim_size]);
  endfunction
  // Stable three-way sort on the split axis: left <= parent <= right.
  function automatic ce_t ce_model(center_t l, center_t p, center_t r, axis_t ax);
    center_t v[3];
    center_t t;
    v[0] = l; v[1] = p; v[2] = r;
    for (int k = 0; k < 3; k++) begin
      int j = k % 2;
      if (key(v[j], ax) > key(v[j+1], ax)) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    end
    return '{l: v[0], p: v[1], r: v[2], sw: {v[0] != l, v[1] != p, v[2] != r}};
  endfunction
  function automatic int rank(int i, int lv);
    int d = depth_of(i);
    return (2 * (i + 1 - 2 ** d) + 1) * 2 ** (lv - 1 - d) - 1;
  endfunction
  function automatic center_t val(int r);
    return {3{8'(r * 16 + 3)}};
  endfunction

  always_comb ce_a = ce_model(bus_a.ce_left, bus_a.ce_parent, bus_a.ce_right, bus_a.ce_axis);
  always_comb ce_b = ce_model(bus_b.ce_left, bus_b.ce_parent, bus_b.ce_right, bus_b.ce_axis);
  assign bus_a.ce_new_left = ce_a.l;
  assign bus_a.ce_new_parent = ce_a.p;
  assign bus_a.ce_new_right = ce_a.r;
  assign {bus_a.ce_left_switch, bus_a.ce_parent_switch, bus_a.ce_right_switch} = ce_a.sw;
  assign bus_b.ce_new_left = ce_b.l;
  assign bus_b.ce_new_parent = ce_b.p;
  assign bus_b.ce_new_right = ce_b.r;
  assign {bus_b.ce_left_switch, bus_b.ce_parent_switch, bus_b.ce_right_switch} = ce_b.sw;

  always @(posedge clk) begin
    if (load_a) mem_a <= img_a;
    else begin
      if (bus_a.mem_re) bus_a.mem_rdata <= mem_a[bus_a.mem_raddr];
      if (bus_a.mem_we) begin
        mem_a[bus_a.mem_waddr] <= bus_a.mem_wdata;
        obs_wr_a.push_back({4'(bus_a.mem_waddr), bus_a.mem_wdata});
      end
      if (bus_a.ce_en) obs_ax_a.push_back(int'(bus_a.ce_axis));
    end
  end
  always @(posedge clk) begin
    if (load_b) mem_b <= img_b;
    else begin
      if (bus_b.mem_re) bus_b.mem_rdata <= mem_b[bus_b.mem_raddr];
      if (bus_b.mem_we) begin
        mem_b[bus_b.mem_waddr] <= bus_b.mem_wdata;
        obs_wr_b.push_back({4'(bus_b.mem_waddr), bus_b.mem_wdata});
      end
      if (bus_b.ce_en) obs_ax_b.push_back(int'(bus_b.ce_axis));
    end
  end

  task automatic load(input bit use_b, input bit swap);
    for (int i = 0; i < (use_b ? 15 : 7); i++) begin
      int k = (swap && i < 2) ? 1 - i : i;
      if (use_b) img_b[i] = val(rank(k, 4)); else img_a[i] = val(rank(k, 3));
    end
    @(negedge clk); load_a = !use_b; load_b = use_b;
    @(negedge clk); load_a = 0; load_b = 0;
  endtask
  // Pulses start, returns the cycle in which done shows (start edge is edge 0), or -1.
  task automatic go(input bit use_b, input int budget, input int pulse_at, output int cyc);
    @(negedge clk); start_a = !use_b; start_b = use_b;
    @(posedge clk); #1 start_a = 0; start_b = 0;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (use_b ? done_b : done_a) begin start_a = 0; return; end
      start_a = (cyc == pulse_at);
      @(posedge clk);
    end
    start_a = 0;
    cyc = -1;
  endtask

  task automatic test_reset();
    vectors++; if ({busy_a, done_a, timeout_a, pass_a} !== '0) begin miscompares++; $display("FAIL reset_ctrl: got %h want 0", {busy_a, done_a, timeout_a, pass_a}); end
    vectors++; if ({bus_a.mem_re, bus_a.mem_we, bus_a.mem_raddr, bus_a.mem_waddr, bus_a.mem_wdata} !== '0) begin miscompares++; $display("FAIL reset_mem: got %h want 0", {bus_a.mem_re, bus_a.mem_we, bus_a.mem_raddr, bus_a.mem_waddr, bus_a.mem_wdata}); end
    vectors++; if ({bus_a.ce_en, bus_a.ce_sorting, bus_a.ce_left, bus_a.ce_parent, bus_a.ce_right, bus_a.ce_axis} !== '0) begin miscompares++; $display("FAIL reset_ce: got %h want 0", {bus_a.ce_en, bus_a.ce_sorting, bus_a.ce_left, bus_a.ce_parent, bus_a.ce_right, bus_a.ce_axis}); end
    vectors++; if ({busy_b, done_b, timeout_b, pass_b, bus_b.mem_re, bus_b.mem_we} !== '0) begin miscompares++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, timeout_b, pass_b, bus_b.mem_re, bus_b.mem_we}); end
  endtask

  task automatic test_sorted();
    int cyc, wb = obs_wr_a.size(), ab = obs_ax_a.size();
    load(0, 0);
    for (int i = 0; i < 3; i++) exp_ax.push_back(depth_of(i) % dim);
    go(0, 200, -1, cyc);
    vectors++; if (cyc != 19) begin miscompares++; $display("FAIL sorted_done_cycle: got %0d want 19", cyc); end
    vectors++; if (pass_a !== 4'd1) begin miscompares++; $display("FAIL sorted_pass_cnt: got %0d want 1", pass_a); end
    vectors++; if (timeout_a !== 1'b0) begin miscompares++; $display("FAIL sorted_timeout: got %b want 0", timeout_a); end
    vectors++; if (obs_wr_a.size() != wb) begin miscompares++; $display("FAIL sorted_writes: got %0d want 0", obs_wr_a.size() - wb); end
    vectors++; if (obs_ax_a.size() - ab != exp_ax.size()) begin miscompares++; $display("FAIL sorted_evals: got %0d want %0d", obs_ax_a.size() - ab, exp_ax.size()); end
    while (exp_ax.size() > 0 && ab < obs_ax_a.size()) begin
      int e = exp_ax.pop_front();
      vectors++; if (obs_ax_a[ab] !== e) begin miscompares++; $display("FAIL sorted_axis[%0d]: got %0d want %0d", ab, obs_ax_a[ab], e); end
      ab++;
    end
    exp_ax.delete();
    @(negedge clk);
    vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL sorted_done_pulse: got %b want 0", done_a); end
  endtask

  task automatic test_root_swap();
    int cyc, wb = obs_wr_a.size(), ab = obs_ax_a.size();
    load(0, 1);
    exp_wr.push_back('{addr: 4'd1, data: val(1)});
    exp_wr.push_back('{addr: 4'd0, data: val(3)});
    for (int p = 0; p < 2; p++) for (int i = 0; i < 3; i++) exp_ax.push_back(depth_of(i) % dim);
    go(0, 200, -1, cyc);
    vectors++; if (cyc != 39) begin miscompares++; $display("FAIL swap_done_cycle: got %0d want 39", cyc); end
    vectors++; if (pass_a !== 4'd2) begin miscompares++; $display("FAIL swap_pass_cnt: got %0d want 2", pass_a); end
    vectors++; if (timeout_a !== 1'b0) begin miscompares++; $display("FAIL swap_timeout: got %b want 0", timeout_a); end
    vectors++; if (obs_wr_a.size() - wb != exp_wr.size()) begin miscompares++; $display("FAIL swap_write_count: got %0d want %0d", obs_wr_a.size() - wb, exp_wr.size()); end
    while (exp_wr.size() > 0 && wb < obs_wr_a.size()) begin
      wr_t w = exp_wr.pop_front();
      vectors++; if (obs_wr_a[wb] !== w) begin miscompares++; $display("FAIL swap_write: got %h want %h", obs_wr_a[wb], w); end
      wb++;
    end
    exp_wr.delete();
    vectors++; if (obs_ax_a.size() - ab != exp_ax.size()) begin miscompares++; $display("FAIL swap_evals: got %0d want %0d", obs_ax_a.size() - ab, exp_ax.size()); end
    while (exp_ax.size() > 0 && ab < obs_ax_a.size()) begin
      int e = exp_ax.pop_front();
      vectors++; if (obs_ax_a[ab] !== e) begin miscompares++; $display("FAIL swap_axis[%0d]: got %0d want %0d", ab, obs_ax_a[ab], e); end
      ab++;
    end
    exp_ax.delete();
    for (int i = 0; i < 7; i++) begin
      vectors++; if (mem_a[i] !== val(rank(i, 3))) begin miscompares++; $display("FAIL swap_ram[%0d]: got %h want %h", i, mem_a[i], val(rank(i, 3))); end
    end
  endtask

  task automatic test_timeout();
    int cyc, wb = obs_wr_b.size(), ab = obs_ax_b.size();
    load(1, 1);
    exp_wr.push_back('{addr: 4'd1, data: val(3)});
    exp_wr.push_back('{addr: 4'd0, data: val(7)});
    for (int i = 0; i < 7; i++) exp_ax.push_back(depth_of(i) % dim);
    go(1, 300, -1, cyc);
    vectors++; if (cyc != 45) begin miscompares++; $display("FAIL limit_done_cycle: got %0d want 45", cyc); end
    vectors++; if (pass_b !== 1'b1) begin miscompares++; $display("FAIL limit_pass_cnt: got %0d want 1", pass_b); end
    vectors++; if (timeout_b !== 1'b1) begin miscompares++; $display("FAIL limit_timeout: got %b want 1", timeout_b); end
    vectors++; if (obs_wr_b.size() - wb != exp_wr.size()) begin miscompares++; $display("FAIL limit_write_count: got %0d want %0d", obs_wr_b.size() - wb, exp_wr.size()); end
    while (exp_wr.size() > 0 && wb < obs_wr_b.size()) begin
      wr_t w = exp_wr.pop_front();
      vectors++; if (obs_wr_b[wb] !== w) begin miscompares++; $display("FAIL limit_write: got %h want %h", obs_wr_b[wb], w); end
      wb++;
    end
    exp_wr.delete();
    vectors++; if (obs_ax_b.size() - ab != exp_ax.size()) begin miscompares++; $display("FAIL limit_evals: got %0d want %0d", obs_ax_b.size() - ab, exp_ax.size()); end
    while (exp_ax.size() > 0 && ab < obs_ax_b.size()) begin
      int e = exp_ax.pop_front();
      vectors++; if (obs_ax_b[ab] !== e) begin miscompares++; $display("FAIL limit_axis[node %0d]: got %0d want %0d", ab, obs_ax_b[ab], e); end
      ab++;
    end
    exp_ax.delete();
    repeat (3) @(negedge clk);
    vectors++; if ({timeout_b, done_b, busy_b} !== 3'b100) begin miscompares++; $display("FAIL limit_timeout_held: got %b want 100", {timeout_b, done_b, busy_b}); end
  endtask

  task automatic test_start_ignored();
    int cyc, extra = 0, ab = obs_ax_a.size();
    load(0, 0);
    for (int i = 0; i < 3; i++) exp_ax.push_back(depth_of(i) % dim);
    go(0, 200, 5, cyc);
    vectors++; if (cyc != 19) begin miscompares++; $display("FAIL busy_start_done_cycle: got %0d want 19", cyc); end
    vectors++; if (pass_a !== 4'd1) begin miscompares++; $display("FAIL busy_start_pass_cnt: got %0d want 1", pass_a); end
    repeat (25) begin @(negedge clk); extra += int'(busy_a) + int'(done_a); end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL busy_start_rerun: got %0d active cycles want 0", extra); end
    vectors++; if (obs_ax_a.size() - ab != exp_ax.size()) begin miscompares++; $display("FAIL busy_start_evals: got %0d want %0d", obs_ax_a.size() - ab, exp_ax.size()); end
    exp_ax.delete();
  endtask

  task automatic test_reset_mid_write();
    int cyc, wb = obs_wr_a.size();
    bit found = 0;
    load(0, 1);
    exp_wr.push_back('{addr: 4'd1, data: val(1)});
    @(negedge clk); start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int n = 0; n < 60 && !found; n++) begin @(negedge clk); found = bus_a.mem_we && bus_a.mem_waddr == 3'd0; end
    vectors++; if (!found || busy_a !== 1'b1) begin miscompares++; $display("FAIL rst_wr_p_reached: got found=%b busy=%b want 1 1", found, busy_a); end
    #1 rst = 0;
    #1;
    vectors++; if ({busy_a, done_a, timeout_a, pass_a, bus_a.mem_re, bus_a.mem_we, bus_a.mem_waddr, bus_a.mem_wdata} !== '0) begin miscompares++; $display("FAIL rst_async_outs: got %h want 0", {busy_a, done_a, timeout_a, pass_a, bus_a.mem_re, bus_a.mem_we, bus_a.mem_waddr, bus_a.mem_wdata}); end
    vectors++; if ({bus_a.ce_en, bus_a.ce_left, bus_a.ce_parent, bus_a.ce_right, bus_a.ce_axis} !== '0) begin miscompares++; $display("FAIL rst_async_ce: got %h want 0", {bus_a.ce_en, bus_a.ce_left, bus_a.ce_parent, bus_a.ce_right, bus_a.ce_axis}); end
    @(negedge clk);
    vectors++; if ({busy_a, bus_a.mem_we, bus_a.mem_re} !== 3'b000) begin miscompares++; $display("FAIL rst_next_cycle: got %b want 000", {busy_a, bus_a.mem_we, bus_a.mem_re}); end
    rst = 1;
    vectors++; if (mem_a[0] !== val(1) || mem_a[1] !== val(1)) begin miscompares++; $display("FAIL rst_ram_abandoned: got %h %h want %h %h", mem_a[0], mem_a[1], val(1), val(1)); end
    vectors++; if (obs_wr_a.size() - wb != exp_wr.size()) begin miscompares++; $display("FAIL rst_write_count: got %0d want %0d", obs_wr_a.size() - wb, exp_wr.size()); end
    while (exp_wr.size() > 0 && wb < obs_wr_a.size()) begin
      wr_t w = exp_wr.pop_front();
      vectors++; if (obs_wr_a[wb] !== w) begin miscompares++; $display("FAIL rst_write: got %h want %h", obs_wr_a[wb], w); end
      wb++;
    end
    exp_wr.delete();
    go(0, 200, -1, cyc);
    vectors++; if (cyc != 19 || pass_a !== 4'd1 || timeout_a !== 1'b0) begin miscompares++; $display("FAIL rst_rerun: got cycle=%0d pass=%0d timeout=%b want 19 1 0", cyc, pass_a, timeout_a); end
    vectors++; if (obs_wr_a.size() != wb) begin miscompares++; $display("FAIL rst_rerun_writes: got %0d want 0", obs_wr_a.size() - wb); end
    for (int i = 0; i < 3; i++) begin
      axis_t ax = axis_t'(depth_of(i) % dim);
      int kl = key(mem_a[left_child(i)], ax), kp = key(mem_a[i], ax), kr = key(mem_a[right_child(i)], ax);
      vectors++; if (!(kl <= kp && kp <= kr)) begin miscompares++; $display("FAIL rst_sorted[%0d]: got %0d %0d %0d want nondecreasing", i, kl, kp, kr); end
    end
  endtask

  initial begin
    rst = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1;
    @(negedge clk);
    test_sorted();
    test_root_swap();
    test_timeout();
    test_start_ignored();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
